// File: rtl/sr_excitation_sequencer.sv
// ---------------------------------------------------------------------------
// sr_excitation_sequencer
//
// Drive side of an SR flip-flop. It walks an attached SR storage element
// through a loaded target bit pattern. The sequencer keeps its own model of
// Q and issues S/R drive from the SR excitation table. It also checks the
// element's Q, fed back on Q_FB, against the value it expects.
//
// Run timeline (eK is the K-th rising edge, where e0 accepts START):
//   e0            capture PATTERN/LEN, drive a clear (S=0, R=1)
//   e1 .. eLEN    issue pattern bits 0 .. LEN-1
//   e(LEN+1)      stop driving (S=0, R=0)
//   e2 .. e(LEN+2) compare Q_FB with the target issued two edges earlier
//   e(LEN+2)      last check, DONE pulse, back to IDLE
//
// Ports:
//   CLK      clock, all state changes on the rising edge
//   RST      asynchronous active-high reset
//   START    run request, sampled only in IDLE
//   PATTERN  target Q sequence, bit 0 first, captured on the accepted START
//   LEN      number of bits to run; 0 or values above N are treated as N
//   Q_FB     Q output of the driven flip-flop
//   S, R     registered set/reset drive, never both high
//   BUSY     high while a run is in progress
//   DONE     one-cycle pulse at the end of a run
//   ERR      sticky mismatch flag for the current or last run
//   ERR_IDX  step index of the first mismatch (step 0 is the clear)
// ---------------------------------------------------------------------------
module sr_excitation_sequencer #(
  parameter int N  = 8,
  parameter int IW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [N-1:0]  PATTERN,
  input  logic [IW-1:0] LEN,
  input  logic          Q_FB,
  output logic          S,
  output logic          R,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [IW-1:0] ERR_IDX
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [IW-1:0] N_IW = IW'(N);

  // Selects bit i of v. A shift is used so the index width need not match
  // the pattern's address width.
  function automatic logic bit_at(input logic [N-1:0] v, input logic [IW-1:0] i);
    logic [N-1:0] sh;
    sh = v >> i;
    return sh[0];
  endfunction

  // SR excitation table: returns {S, R} that moves Q from m to t.
  // A hold (t == m) leaves both inputs low, so S and R are never both high.
  function automatic logic [1:0] excite(input logic m, input logic t);
    return {~m & t, m & ~t};
  endfunction

  state_t        state, state_nxt;
  logic [N-1:0]  pat, pat_nxt;
  logic [IW-1:0] len, len_nxt;
  logic [IW-1:0] idx, idx_nxt;        // next pattern bit to issue
  logic [IW-1:0] chk_step, chk_nxt;   // step number of the next check
  logic          model, model_nxt;    // expected Q after the last issued drive
  logic          exp1, exp1_nxt;      // target issued one edge ago
  logic          exp2, exp2_nxt;      // target issued two edges ago
  logic          s_nxt, r_nxt;
  logic          busy_nxt, done_nxt;
  logic          err_nxt;
  logic [IW-1:0] err_idx_nxt;
  logic          issue_bit;
  logic          chk_en;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values of the others.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      pat      <= '0;
      len      <= '0;
      idx      <= '0;
      chk_step <= '0;
      model    <= 1'b0;
      exp1     <= 1'b0;
      exp2     <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      ERR_IDX  <= '0;
    end else begin
      state    <= state_nxt;
      pat      <= pat_nxt;
      len      <= len_nxt;
      idx      <= idx_nxt;
      chk_step <= chk_nxt;
      model    <= model_nxt;
      exp1     <= exp1_nxt;
      exp2     <= exp2_nxt;
      S        <= s_nxt;
      R        <= r_nxt;
      BUSY     <= busy_nxt;
      DONE     <= done_nxt;
      ERR      <= err_nxt;
      ERR_IDX  <= err_idx_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    pat_nxt     = pat;
    len_nxt     = len;
    idx_nxt     = idx;
    chk_nxt     = chk_step;
    model_nxt   = model;
    exp1_nxt    = 1'b0;
    exp2_nxt    = exp1;       // expected-value pipeline always advances
    s_nxt       = 1'b0;
    r_nxt       = 1'b0;
    busy_nxt    = BUSY;
    done_nxt    = 1'b0;
    err_nxt     = ERR;
    err_idx_nxt = ERR_IDX;
    issue_bit   = 1'b0;
    chk_en      = 1'b0;

    unique case (state)
      IDLE: begin
        if (START) begin
          pat_nxt     = PATTERN;
          len_nxt     = (LEN == '0 || LEN > N_IW) ? N_IW : LEN;
          err_nxt     = 1'b0;
          err_idx_nxt = '0;
          busy_nxt    = 1'b1;
          r_nxt       = 1'b1;   // clear drive: the flip-flop's Q goes to 0
          model_nxt   = 1'b0;
          exp1_nxt    = 1'b0;   // step 0 expects the cleared value
          state_nxt   = CLEAR;
        end
      end

      CLEAR: begin
        // Issue pattern bit 0 on the edge that leaves CLEAR.
        issue_bit        = pat[0];
        {s_nxt, r_nxt}   = excite(model, issue_bit);
        model_nxt        = issue_bit;
        exp1_nxt         = issue_bit;
        idx_nxt          = IW'(1);
        chk_nxt          = '0;
        state_nxt        = RUN;
      end

      RUN: begin
        chk_en = 1'b1;
        if (idx == len) begin
          // All bits issued: stop driving and collect the last check.
          state_nxt = DRAIN;
        end else begin
          issue_bit      = bit_at(pat, idx);
          {s_nxt, r_nxt} = excite(model, issue_bit);
          model_nxt      = issue_bit;
          exp1_nxt       = issue_bit;
          idx_nxt        = idx + IW'(1);
        end
      end

      DRAIN: begin
        chk_en    = 1'b1;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    // Feedback check. Only the first mismatch of a run is recorded, so
    // ERR_IDX points at the earliest failing step.
    if (chk_en) begin
      chk_nxt = chk_step + IW'(1);
      if ((Q_FB != exp2) && !ERR) begin
        err_nxt     = 1'b1;
        err_idx_nxt = chk_step;
      end
    end
  end

endmodule

// File: tb/tb_sr_excitation_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sr_excitation_sequencer
//
// Directed bench for sr_excitation_sequencer. A behavioural SR flip-flop
// closes the loop from S/R back to Q_FB. An override lets a scenario force
// Q_FB to a chosen value so that it can inject mismatches. Inputs are driven
// and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sr_excitation_sequencer;

  localparam int N  = 8;
  localparam int IW = 4;

  logic          CLK;
  logic          RST;
  logic          START;
  logic [N-1:0]  PATTERN;
  logic [IW-1:0] LEN;
  logic          Q_FB;
  logic          S;
  logic          R;
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic [IW-1:0] ERR_IDX;

  int total;
  int bad;

  // Behavioural SR flip-flop driven by the sequencer.
  logic ff_q;
  logic ovr_en;
  logic ovr_val;

  always @(posedge CLK or posedge RST) begin
    if (RST)             ff_q <= 1'b0;
    else if (S && !R)    ff_q <= 1'b1;
    else if (R && !S)    ff_q <= 1'b0;
  end

  assign Q_FB = ovr_en ? ovr_val : ff_q;

  sr_excitation_sequencer #(.N(N), .IW(IW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .PATTERN (PATTERN),
    .LEN     (LEN),
    .Q_FB    (Q_FB),
    .S       (S),
    .R       (R),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR),
    .ERR_IDX (ERR_IDX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // S and R must never be high together, in any scenario.
  always @(negedge CLK) begin
    if (!RST) begin
      total++;
      if (S === 1'b1 && R === 1'b1) begin
        bad++;
        $display("FAIL s_and_r_exclusive: S=%b R=%b, need not both 1 (t=%0t)", S, R, $time);
      end
    end
  end

  // Advance to the falling edge after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Present a run request. The call returns at the falling edge after e0.
  task automatic do_start(input logic [N-1:0] p, input logic [IW-1:0] l);
    @(negedge CLK);
    PATTERN = p;
    LEN     = l;
    START   = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START   = 1'b0;
  endtask

  // Tick until DONE is seen or the budget runs out. cyc counts the edges
  // taken, including the one that raised DONE.
  task automatic run_to_done(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (DONE === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #1 RST = 1'b1;
    #1;
    total++;
    if ({S, R, BUSY, DONE, ERR, ERR_IDX} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got S=%b R=%b BUSY=%b DONE=%b ERR=%b ERR_IDX=%0d, need all 0",
               S, R, BUSY, DONE, ERR, ERR_IDX);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_pattern_b2();
    logic [1:0] exp_sr [8];
    exp_sr = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
    do_start(8'b1011_0010, 4'd8);
    total++;
    if ({S, R, BUSY} !== 3'b011) begin
      bad++;
      $display("FAIL b2_clear: got S=%b R=%b BUSY=%b, need 0 1 1", S, R, BUSY);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if ({S, R} !== exp_sr[k]) begin
        bad++;
        $display("FAIL b2_bit%0d_sr: got %b%b, need %b", k, S, R, exp_sr[k]);
      end
    end
    tick(); // e9
    total++;
    if ({S, R, DONE, BUSY} !== 4'b0001) begin
      bad++;
      $display("FAIL b2_drain: got S=%b R=%b DONE=%b BUSY=%b, need 0 0 0 1", S, R, DONE, BUSY);
    end
    tick(); // e10
    total++;
    if ({DONE, BUSY, ERR} !== 3'b100) begin
      bad++;
      $display("FAIL b2_done: got DONE=%b BUSY=%b ERR=%b, need 1 0 0", DONE, BUSY, ERR);
    end
    tick(); // e11
    total++;
    if (DONE !== 1'b0) begin
      bad++;
      $display("FAIL b2_done_pulse: DONE=%b one cycle after the pulse, need 0", DONE);
    end
  endtask

  task automatic test_stuck_low();
    ovr_en  = 1'b1;
    ovr_val = 1'b0;
    do_start(8'h01, 4'd1);
    tick(); // e1
    tick(); // e2: step 0 check passes
    total++;
    if ({ERR, DONE} !== 2'b00) begin
      bad++;
      $display("FAIL stuck_e2: got ERR=%b DONE=%b, need 0 0", ERR, DONE);
    end
    tick(); // e3: step 1 fails
    total++;
    if ({DONE, ERR} !== 2'b11 || ERR_IDX !== 4'd1) begin
      bad++;
      $display("FAIL stuck_e3: got DONE=%b ERR=%b ERR_IDX=%0d, need 1 1 1", DONE, ERR, ERR_IDX);
    end
    ovr_en = 1'b0;
    tick();
  endtask

  task automatic test_failed_clear();
    do_start(8'h0F, 4'd8);
    tick(); // e1
    ovr_en  = 1'b1;
    ovr_val = 1'b1;
    tick(); // e2: clear reads back as 1
    ovr_en  = 1'b0;
    total++;
    if (ERR !== 1'b1 || ERR_IDX !== 4'd0) begin
      bad++;
      $display("FAIL clear_err: got ERR=%b ERR_IDX=%0d, need 1 0", ERR, ERR_IDX);
    end
    tick(); // e3
    tick(); // e4
    ovr_en  = 1'b1;
    ovr_val = 1'b0;   // step 3 expects pattern bit 2 = 1
    tick(); // e5
    ovr_en  = 1'b0;
    total++;
    if (ERR !== 1'b1 || ERR_IDX !== 4'd0) begin
      bad++;
      $display("FAIL clear_err_sticky: got ERR=%b ERR_IDX=%0d, need 1 0", ERR, ERR_IDX);
    end
    repeat (5) tick(); // e10
    total++;
    if ({DONE, ERR} !== 2'b11 || ERR_IDX !== 4'd0) begin
      bad++;
      $display("FAIL clear_done: got DONE=%b ERR=%b ERR_IDX=%0d, need 1 1 0", DONE, ERR, ERR_IDX);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit got;
    do_start(8'hFF, 4'd0);
    total++;
    if (ERR !== 1'b0 || ERR_IDX !== 4'd0) begin
      bad++;
      $display("FAIL b2b_err_cleared: got ERR=%b ERR_IDX=%0d, need 0 0", ERR, ERR_IDX);
    end
    for (int c = 1; c <= 9; c++) begin
      if (c == 4 || c == 7) START = 1'b1;
      tick();
      START = 1'b0;
      total++;
      if (DONE !== 1'b0 || BUSY !== 1'b1) begin
        bad++;
        $display("FAIL b2b_busy_e%0d: got DONE=%b BUSY=%b, need 0 1", c, DONE, BUSY);
      end
      if (c == 1) begin
        total++;
        if ({S, R} !== 2'b10) begin
          bad++;
          $display("FAIL b2b_bit0_sr: got %b%b, need 10", S, R);
        end
      end
    end
    START = 1'b1;     // held through the DONE cycle
    tick(); // e10
    total++;
    if ({DONE, BUSY, ERR} !== 3'b100) begin
      bad++;
      $display("FAIL b2b_done_e10: got DONE=%b BUSY=%b ERR=%b, need 1 0 0", DONE, BUSY, ERR);
    end
    tick(); // e11: new run accepted
    START = 1'b0;
    total++;
    if ({S, R, BUSY, DONE} !== 4'b0110) begin
      bad++;
      $display("FAIL b2b_restart: got S=%b R=%b BUSY=%b DONE=%b, need 0 1 1 0", S, R, BUSY, DONE);
    end
    run_to_done(cyc, got);
    total++;
    if (!got || cyc != 10 || ERR !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second_run: got done=%0d after %0d edges ERR=%b, need 1 after 10, ERR 0",
               got, cyc, ERR);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    bit got;
    int dones;
    do_start(8'h55, 4'd8);
    repeat (3) tick(); // e3
    #2 RST = 1'b1;
    #1;
    total++;
    if ({S, R, BUSY, DONE} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_immediate: got S=%b R=%b BUSY=%b DONE=%b, need 0 0 0 0", S, R, BUSY, DONE);
    end
    #1 RST = 1'b0;
    dones = 0;
    repeat (12) begin
      tick();
      if (DONE === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_done: got %0d DONE pulses BUSY=%b, need 0 and 0", dones, BUSY);
    end
    do_start(8'hC3, 4'd8);
    run_to_done(cyc, got);
    total++;
    if (!got || cyc != 10 || ERR !== 1'b0) begin
      bad++;
      $display("FAIL rst_rerun: got done=%0d after %0d edges ERR=%b, need 1 after 10, ERR 0",
               got, cyc, ERR);
    end
  endtask

  task automatic test_patterns();
    logic [N-1:0] pats [4];
    pats = '{8'h55, 8'hAA, 8'hFF, 8'h00};
    for (int p = 0; p < 4; p++) begin
      do_start(pats[p], 4'd8);
      for (int c = 1; c <= 10; c++) begin
        tick();
        total++;
        if (ERR !== 1'b0) begin
          bad++;
          $display("FAIL pat_%h_err_e%0d: ERR=%b ERR_IDX=%0d, need ERR 0", pats[p], c, ERR, ERR_IDX);
        end
        if (c == 10) begin
          total++;
          if (DONE !== 1'b1) begin
            bad++;
            $display("FAIL pat_%h_done: DONE=%b at e10, need 1", pats[p], DONE);
          end
        end
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    START   = 1'b0;
    PATTERN = '0;
    LEN     = '0;
    ovr_en  = 1'b0;
    ovr_val = 1'b0;
    test_reset();
    test_pattern_b2();
    test_stuck_low();
    test_failed_clear();
    test_back_to_back();
    test_async_reset();
    test_patterns();
    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
